ecg_peak_detector: RTL and testbench



---
 rtl/ecg_pkg.sv | 21 ++
 rtl/ecg_peak_core.sv | 149 ++++++++++++++
 rtl/ecg_peak_detector.sv | 117 +++++++++++
 tb/tb_ecg_peak_detector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// ecg_pkg: shared types and default constants for the ECG R-peak detector.
//   fetch_state_t : FIFO fetch FSM states (IDLE, CAPTURE, EVAL)
//   det_mode_t    : detector modes (SEARCH, TRACK, REFRACT)
package ecg_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int REFRACT_SAMPLES_DEF = 50;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    EVAL    = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } det_mode_t;

endpackage

// File: rtl/ecg_peak_core.sv
// ecg_peak_core: one detector step per strobe (threshold / max-tracking /
// refractory), plus peak reporting and R-R arithmetic.
// Optional build macro: ECG_PEAK_STATS_EN adds peak_count_o, rr_min_o, rr_max_o.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   step_i            one-cycle strobe: evaluate sample_i at index idx_i
//   sample_i          signed sample under evaluation
//   thresh_i          signed threshold
//   idx_i             sample index of sample_i
//   peak_valid_o      one-cycle pulse per emitted peak
//   peak_amp_o        amplitude of the last peak (held)
//   peak_idx_o        index of the last peak (held)
//   rr_interval_o     peak_idx minus previous peak_idx, modulo 2^IDX_WIDTH (held)
//   rr_valid_o        low for the first peak after reset (held)
module ecg_peak_core
  import ecg_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH       = 24,
  parameter int REFRACT_SAMPLES = REFRACT_SAMPLES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic signed [DATA_WIDTH-1:0] thresh_i,
  input  logic        [IDX_WIDTH-1:0]  idx_i,
  output logic                         peak_valid_o,
  output logic signed [DATA_WIDTH-1:0] peak_amp_o,
  output logic        [IDX_WIDTH-1:0]  peak_idx_o,
  output logic        [IDX_WIDTH-1:0]  rr_interval_o,
  output logic                         rr_valid_o
`ifdef ECG_PEAK_STATS_EN
  ,
  output logic        [15:0]           peak_count_o,
  output logic        [IDX_WIDTH-1:0]  rr_min_o,
  output logic        [IDX_WIDTH-1:0]  rr_max_o
`endif
);

  localparam int RW = (REFRACT_SAMPLES > 1) ? $clog2(REFRACT_SAMPLES + 1) : 1;
  localparam logic [RW-1:0] REFRACT_LD = RW'(REFRACT_SAMPLES);
  localparam logic [RW-1:0] CNT_ONE    = RW'(1);

  det_mode_t                   mode_q, mode_d;
  logic        [RW-1:0]        cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic        [IDX_WIDTH-1:0] max_idx_q, max_idx_d;
  logic        [IDX_WIDTH-1:0] last_idx_q;
  logic                        first_q;
  logic                        emit;
  logic        [IDX_WIDTH-1:0] rr_new;

  assign rr_new = max_idx_q - last_idx_q;

  always_comb begin
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    emit      = 1'b0;
    if (step_i) begin
      unique case (mode_q)
        SEARCH: begin
          if (sample_i > thresh_i) begin
            mode_d    = TRACK;
            max_d     = sample_i;
            max_idx_d = idx_i;
          end
        end
        TRACK: begin
          if (sample_i <= thresh_i) begin
            emit = 1'b1;
            if (REFRACT_SAMPLES == 0) begin
              mode_d = SEARCH;
            end else begin
              mode_d = REFRACT;
              cnt_d  = REFRACT_LD;
            end
          end else if (sample_i > max_q) begin
            // strict compare: an equal later sample keeps the earlier index
            max_d     = sample_i;
            max_idx_d = idx_i;
          end
        end
        REFRACT: begin
          // the sample that brings the counter to zero is discarded too
          if (cnt_q <= CNT_ONE) begin
            cnt_d  = '0;
            mode_d = SEARCH;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: mode_d = SEARCH;
      endcase
    end
  end

  // Control and reported outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= SEARCH;
      cnt_q         <= '0;
      last_idx_q    <= '0;
      first_q       <= 1'b1;
      peak_valid_o  <= 1'b0;
      peak_amp_o    <= '0;
      peak_idx_o    <= '0;
      rr_interval_o <= '0;
      rr_valid_o    <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      peak_valid_o <= emit;
      if (emit) begin
        peak_amp_o    <= max_q;
        peak_idx_o    <= max_idx_q;
        rr_interval_o <= rr_new;
        rr_valid_o    <= ~first_q;
        last_idx_q    <= max_idx_q;
        first_q       <= 1'b0;
      end
    end
  end

  // Tracking datapath; only read while in TRACK, so no reset needed
  always_ff @(posedge clk) begin
    max_q     <= max_d;
    max_idx_q <= max_idx_d;
  end

`ifdef ECG_PEAK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_count_o <= '0;
      rr_min_o     <= '1;
      rr_max_o     <= '0;
    end else if (emit) begin
      if (peak_count_o != 16'hFFFF) peak_count_o <= peak_count_o + 16'd1;
      if (!first_q) begin
        if (rr_new < rr_min_o) rr_min_o <= rr_new;
        if (rr_new > rr_max_o) rr_max_o <= rr_new;
      end
    end
  end
`endif

endmodule

// File: rtl/ecg_peak_detector.sv
// ecg_peak_detector: drains signed ECG samples from a synchronous FIFO and
// reports R-peaks (amplitude, index, R-R interval).
// Optional build macro: ECG_PEAK_STATS_EN adds peak_count, rr_min, rr_max.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              enable draining (an in-flight read always completes)
//   thresh_wr/in    load signed threshold
//   fifo_empty      FIFO empty flag
//   fifo_data       FIFO read data, valid the cycle after the rd_en edge
//   fifo_cs         FIFO chip select, constant high
//   fifo_rd_en      FIFO read strobe, single-cycle
//   peak_valid      one-cycle pulse per peak
//   peak_amp/idx    amplitude and sample index of the last peak
//   rr_interval     index distance to the previous peak
//   rr_valid        low on the first peak after reset
//   busy            fetch FSM not in IDLE
module ecg_peak_detector
  import ecg_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH       = 24,
  parameter int REFRACT_SAMPLES = REFRACT_SAMPLES_DEF,
  parameter int THRESH_DEFAULT  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         thresh_wr,
  input  logic signed [DATA_WIDTH-1:0] thresh_in,
  input  logic                         fifo_empty,
  input  logic signed [DATA_WIDTH-1:0] fifo_data,
  output logic                         fifo_cs,
  output logic                         fifo_rd_en,
  output logic                         peak_valid,
  output logic signed [DATA_WIDTH-1:0] peak_amp,
  output logic        [IDX_WIDTH-1:0]  peak_idx,
  output logic        [IDX_WIDTH-1:0]  rr_interval,
  output logic                         rr_valid,
  output logic                         busy
`ifdef ECG_PEAK_STATS_EN
  ,
  output logic        [15:0]           peak_count,
  output logic        [IDX_WIDTH-1:0]  rr_min,
  output logic        [IDX_WIDTH-1:0]  rr_max
`endif
);

  fetch_state_t                 state_q, state_d;
  logic signed [DATA_WIDTH-1:0] thresh_q;
  logic signed [DATA_WIDTH-1:0] sample_q;
  logic        [IDX_WIDTH-1:0]  idx_q;
  logic                         rd_en;

  assign fifo_cs    = 1'b1;
  assign fifo_rd_en = rd_en;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // no read is launched while reset is held
        if (en && !fifo_empty && !rst) begin
          rd_en   = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      thresh_q <= DATA_WIDTH'(THRESH_DEFAULT);
    end else begin
      state_q <= state_d;
      if (state_q == EVAL) idx_q <= idx_q + IDX_WIDTH'(1);
      if (thresh_wr) thresh_q <= thresh_in;
    end
  end

  // Capture stage: FIFO data is valid during CAPTURE
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) sample_q <= fifo_data;
  end

  // Evaluate stage
  ecg_peak_core #(
    .DATA_WIDTH     (DATA_WIDTH),
    .IDX_WIDTH      (IDX_WIDTH),
    .REFRACT_SAMPLES(REFRACT_SAMPLES)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .step_i       (state_q == EVAL),
    .sample_i     (sample_q),
    .thresh_i     (thresh_q),
    .idx_i        (idx_q),
    .peak_valid_o (peak_valid),
    .peak_amp_o   (peak_amp),
    .peak_idx_o   (peak_idx),
    .rr_interval_o(rr_interval),
    .rr_valid_o   (rr_valid)
`ifdef ECG_PEAK_STATS_EN
    ,
    .peak_count_o (peak_count),
    .rr_min_o     (rr_min),
    .rr_max_o     (rr_max)
`endif
  );

endmodule

// File: tb/tb_ecg_peak_detector.sv
module tb_ecg_peak_detector;

  localparam int DW = 32;
  localparam int IW = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 thresh_wr = 1'b0;
  logic signed [DW-1:0] thresh_in = '0;
  logic                 fifo_empty = 1'b1;
  logic signed [DW-1:0] fifo_data = '0;
  logic                 fifo_cs, fifo_rd_en, peak_valid, rr_valid, busy;
  logic signed [DW-1:0] peak_amp;
  logic        [IW-1:0] peak_idx, rr_interval;
`ifdef ECG_PEAK_STATS_EN
  logic [15:0]   peak_count;
  logic [IW-1:0] rr_min, rr_max;
`endif

  ecg_peak_detector #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .REFRACT_SAMPLES(4), .THRESH_DEFAULT(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .thresh_wr(thresh_wr), .thresh_in(thresh_in),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_cs(fifo_cs),
    .fifo_rd_en(fifo_rd_en), .peak_valid(peak_valid), .peak_amp(peak_amp),
    .peak_idx(peak_idx), .rr_interval(rr_interval), .rr_valid(rr_valid), .busy(busy)
`ifdef ECG_PEAK_STATS_EN
    , .peak_count(peak_count), .rr_min(rr_min), .rr_max(rr_max)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint amp;
    longint idx;
    longint rr;
    longint rrv;
  } exp_t;

  exp_t                 sb[$];
  logic signed [DW-1:0] fq[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  pend     = 1'b0;
  bit  gaps_on  = 1'b0;
  int  gap      = 0;
  int  pops     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_peak(input longint amp, input longint idx, input longint rr,
                             input longint rrv);
    exp_t e;
    e.amp = amp; e.idx = idx; e.rr = rr; e.rrv = rrv;
    sb.push_back(e);
  endtask

  task automatic push_samples(input longint s[]);
    foreach (s[i]) fq.push_back(DW'(s[i]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_thresh(input longint v);
    @(negedge clk);
    thresh_wr = 1'b1;
    thresh_in = DW'(v);
    @(negedge clk);
    thresh_wr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fq.size() != 0 || busy || pend) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d cycles, required < 2000", n);
    end
    repeat (4) @(negedge clk);
  endtask

  // FIFO model: pops during CAPTURE so data is valid the cycle after rd_en
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        fifo_data = fq.pop_front();
        pend = 1'b0;
        pops++;
        if (gaps_on && (pops % 5 == 0)) gap = 6;
      end
      if (gap > 0) gap--;
      fifo_empty = (fq.size() == 0) || (gap > 0);
      #1;
      if (fifo_rd_en) begin
        check("rd_en_not_empty", fifo_empty, 0);
        pend = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && peak_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL peak_spurious: got peak amp %0d idx %0d, expected none",
                   peak_amp, peak_idx);
        end else begin
          e = sb.pop_front();
          check("peak_amp", longint'(peak_amp), e.amp);
          check("peak_idx", longint'(peak_idx), e.idx);
          check("rr_interval", longint'(rr_interval), e.rr);
          check("rr_valid", longint'(rr_valid), e.rrv);
        end
      end
    end
  end

  initial begin
    // Reset / idle
    repeat (3) @(negedge clk);
    check("rst_peak_valid", peak_valid, 0);
    check("rst_peak_amp", peak_amp, 0);
    check("rst_peak_idx", peak_idx, 0);
    check("rst_rr_interval", rr_interval, 0);
    check("rst_rr_valid", rr_valid, 0);
    check("rst_fifo_cs", fifo_cs, 1);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    // Single peak
    set_thresh(100);
    push_samples('{0, 50, 120, 300, 250, 90, 0});
    expect_peak(300, 3, 3, 0);
    en = 1'b1;
    drain();

    // Two peaks
    do_reset();
    set_thresh(100);
    push_samples('{200, 50, 0, 0, 0, 0, 0, 0, 0, 0, 500, 10});
    expect_peak(200, 0, 0, 0);
    expect_peak(500, 10, 10, 1);
    en = 1'b1;
    drain();

    // Refractory window swallows the 400
    do_reset();
    set_thresh(100);
    push_samples('{300, 0, 400, 0});
    expect_peak(300, 0, 0, 0);
    en = 1'b1;
    drain();

    // Reset while tracking discards the peak
    do_reset();
    set_thresh(100);
    push_samples('{150, 400});
    en = 1'b1;
    drain();
    do_reset();
    set_thresh(100);
    push_samples('{200, 0});
    expect_peak(200, 0, 0, 0);
    en = 1'b1;
    drain();

    // Sample equal to threshold, and signed threshold
    do_reset();
    set_thresh(100);
    push_samples('{100, 100, 101, 100});
    expect_peak(101, 2, 2, 0);
    en = 1'b1;
    drain();
    do_reset();
    set_thresh(-50);
    push_samples('{-100, -20, -60});
    expect_peak(-20, 1, 1, 0);
    en = 1'b1;
    drain();

    // Backpressure: empty gaps and en toggling mid-stream; tie keeps index 9
    do_reset();
    set_thresh(100);
    gaps_on = 1'b1;
    push_samples('{0, 150, 0, 0, 0, 0, 0, 0, 250, 300, 300, 0,
                   0, 0, 0, 0, 120, 0});
    expect_peak(150, 1, 1, 0);
    expect_peak(300, 9, 8, 1);
    expect_peak(120, 16, 7, 1);
    en = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    drain();
    gaps_on = 1'b0;

    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
